// File: rtl/if_id_pipe_pkg.sv
// Shared CPU pipeline package: occupancy state encoding and default constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_id_pipe_pkg;

  // Entry-count state of a two-deep pipeline stage. The encoding equals the
  // number of held entries, so the state register drives occupancy directly.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_t;

  // Defaults are kept wide and cast down by users, so any PC/instruction
  // width up to 64 bits can take them.
  localparam logic [63:0] DEF_RESET_PC = 64'h0;
  localparam logic [63:0] DEF_NOP_INST = 64'h0;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_count(input occ_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with a one-entry skid buffer (main + skid).
// Latency: beat accepted at edge N is on id_* after edge N; 1 beat/cycle sustained.
// Backpressure: if_ready is registered; it drops only once both entries are held.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   flush              discards all held entries (rst has priority)
//   if_valid/if_ready  IF handshake; if_pc/if_inst carry the fetched beat
//   id_valid/id_ready  ID handshake; id_pc/id_inst come straight from the main entry
//   occupancy          entries held, 0..2
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int unsigned              ADDR_W   = 32,
  parameter int unsigned              INST_W   = 32,
  parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter logic [INST_W-1:0]        NOP_INST = INST_W'(DEF_NOP_INST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occupancy
);

  occ_state_t        state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic              ready_q, ready_d;
  logic              accept;
  logic              consume;

  assign id_valid  = (state_q != OCC_EMPTY);
  assign accept    = if_valid & ready_q;
  assign consume   = id_valid & id_ready;

  assign if_ready  = ready_q;
  assign id_pc     = main_pc_q;
  assign id_inst   = main_inst_q;
  assign occupancy = occ_count(state_q);

  // Next-state and datapath selection. Main/skid hold their values unless
  // explicitly loaded, which keeps id_* stable while stalled or idle.
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d     = OCC_ONE;
          main_pc_d   = if_pc;
          main_inst_d = if_inst;
        end
      end
      OCC_ONE: begin
        if (accept && consume) begin
          // Pass-through: the departing beat is replaced in the same edge.
          main_pc_d   = if_pc;
          main_inst_d = if_inst;
        end else if (accept) begin
          // ID stalled: park the new beat behind the one on id_*.
          state_d     = OCC_TWO;
          skid_pc_d   = if_pc;
          skid_inst_d = if_inst;
        end else if (consume) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        // if_ready is low here, so only a consume can move the state.
        if (consume) begin
          state_d     = OCC_ONE;
          main_pc_d   = skid_pc_q;
          main_inst_d = skid_inst_q;
          skid_pc_d   = RESET_PC;
          skid_inst_d = NOP_INST;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase

    // Flush overrides any handshake; a beat offered now is dropped.
    if (flush) begin
      state_d     = OCC_EMPTY;
      main_pc_d   = RESET_PC;
      main_inst_d = NOP_INST;
      skid_pc_d   = RESET_PC;
      skid_inst_d = NOP_INST;
    end

    // Registered ready: the skid slot guarantees room for the beat that may
    // be accepted on the same edge this drops.
    ready_d = (state_d != OCC_TWO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= OCC_EMPTY;
      main_pc_q   <= RESET_PC;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= RESET_PC;
      skid_inst_q <= NOP_INST;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      ready_q     <= ready_d;
    end
  end

  // Ready must never be high while both entries are full.
  a_no_ready_when_full : assert property (
    @(posedge clk) disable iff (rst) (state_q == OCC_TWO) |-> !ready_q);

  // A stalled beat must not change under ID.
  a_stall_stable : assert property (
    @(posedge clk) disable iff (rst)
    (id_valid && !id_ready && !flush) |=> ($stable(id_pc) && $stable(id_inst)));

endmodule

// File: tb/tb_if_id_pipe.sv
module tb_if_id_pipe;

  localparam logic [31:0] RST_PC  = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP_IN  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [1:0]  occupancy;

  int          n_checks = 0;
  int          n_fail   = 0;

  beat_t       sb[$];
  bit          model_ok    = 0;
  bit          stalled_prev = 0;
  logic [31:0] held_pc;
  logic [31:0] idle_pc   = RST_PC;
  logic [31:0] idle_inst = NOP_IN;

  if_id_pipe #(
    .ADDR_W   (32),
    .INST_W   (32),
    .RESET_PC (RST_PC),
    .NOP_INST (NOP_IN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .if_ready  (if_ready),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_pc     (id_pc),
    .id_inst   (id_inst),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle with the inputs that the next rising edge will sample:
  // compare outputs against the scoreboard, then apply that edge's effect.
  task automatic model_step();
    int          n;
    logic [31:0] epc;
    logic [31:0] einst;
    bit          acc;
    bit          cons;
    n     = sb.size();
    epc   = (n > 0) ? sb[0].pc   : idle_pc;
    einst = (n > 0) ? sb[0].inst : idle_inst;
    if (model_ok) begin
      chk("occupancy", 64'(occupancy), 64'(n));
      chk("if_ready",  64'(if_ready),  64'(n < 2));
      chk("id_valid",  64'(id_valid),  64'(n > 0));
      chk("id_pc",     64'(id_pc),     64'(epc));
      chk("id_inst",   64'(id_inst),   64'(einst));
      if (stalled_prev) chk("stall_pc", 64'(id_pc), 64'(held_pc));
    end
    stalled_prev = model_ok && !rst && !flush && (n > 0) && !id_ready;
    held_pc      = epc;
    if (n > 0) begin
      idle_pc   = sb[0].pc;
      idle_inst = sb[0].inst;
    end
    if (rst) begin
      sb.delete();
      idle_pc   = RST_PC;
      idle_inst = NOP_IN;
      model_ok  = 1;
    end else if (flush) begin
      sb.delete();
      idle_pc   = RST_PC;
      idle_inst = NOP_IN;
    end else if (model_ok) begin
      acc  = if_valid && (n < 2);
      cons = (n > 0) && id_ready;
      if (cons) void'(sb.pop_front());
      if (acc) sb.push_back('{pc: if_pc, inst: if_inst});
    end
  endtask

  // One clock: drive inputs, run the model mid-cycle, return just after the edge.
  task automatic cycle(input logic r, input logic f, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic rdy);
    rst      = r;
    flush    = f;
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
    id_ready = rdy;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_occ"},   64'(occupancy), 64'(0));
    chk({tag, "_rdy"},   64'(if_ready),  64'(1));
    chk({tag, "_vld"},   64'(id_valid),  64'(0));
    chk({tag, "_pc"},    64'(id_pc),     64'(RST_PC));
    chk({tag, "_inst"},  64'(id_inst),   64'(NOP_IN));
  endtask

  initial begin
    logic [31:0] pc_ctr;
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
    if_pc = '0; if_inst = '0;
    @(posedge clk);
    #1;

    // Reset state.
    cycle(1, 0, 0, 32'h0, 32'h0, 0);
    cycle(1, 0, 1, 32'h99, 32'h99, 1);
    check_reset_values("reset");

    // Back-to-back stream with ID always ready.
    cycle(0, 0, 1, 32'h0, 32'hA000_0000, 1);
    chk("stream_pc0", 64'(id_pc), 64'(32'h0));
    chk("stream_occ0", 64'(occupancy), 64'(1));
    cycle(0, 0, 1, 32'h4, 32'hA000_0004, 1);
    chk("stream_pc1", 64'(id_pc), 64'(32'h4));
    cycle(0, 0, 1, 32'h8, 32'hA000_0008, 1);
    chk("stream_pc2", 64'(id_pc), 64'(32'h8));
    chk("stream_vld2", 64'(id_valid), 64'(1));
    chk("stream_occ2", 64'(occupancy), 64'(1));
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("stream_drained", 64'(occupancy), 64'(0));

    // Backpressure: fill both entries, offer a third that must be refused.
    cycle(0, 0, 1, 32'h10, 32'hB000_0010, 0);
    cycle(0, 0, 1, 32'h14, 32'hB000_0014, 0);
    chk("bp_occ", 64'(occupancy), 64'(2));
    chk("bp_rdy", 64'(if_ready), 64'(0));
    chk("bp_pc", 64'(id_pc), 64'(32'h10));
    cycle(0, 0, 1, 32'h18, 32'hB000_0018, 0);
    chk("bp_hold_pc", 64'(id_pc), 64'(32'h10));
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("bp_next_pc", 64'(id_pc), 64'(32'h14));
    chk("bp_rdy_back", 64'(if_ready), 64'(1));
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("bp_empty", 64'(id_valid), 64'(0));
    chk("bp_idle_pc", 64'(id_pc), 64'(32'h14));

    // Flush while full, with a beat offered in the flush cycle.
    cycle(0, 0, 1, 32'h30, 32'hC000_0030, 0);
    cycle(0, 0, 1, 32'h34, 32'hC000_0034, 0);
    cycle(0, 1, 1, 32'h20, 32'hC000_0020, 0);
    check_reset_values("flush");
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("flush_no_0x20", 64'(id_valid), 64'(0));

    // Reset while full, with flush and a beat also asserted.
    cycle(0, 0, 1, 32'h40, 32'hD000_0040, 0);
    cycle(0, 0, 1, 32'h44, 32'hD000_0044, 0);
    chk("pre_rst_occ", 64'(occupancy), 64'(2));
    cycle(1, 1, 1, 32'h48, 32'hD000_0048, 1);
    check_reset_values("rst_full");
    cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("rst_no_beat", 64'(id_valid), 64'(0));

    // Random handshake traffic against the scoreboard.
    pc_ctr = 32'h1000;
    for (int i = 0; i < 10000; i++) begin
      logic v;
      logic rdy;
      logic f;
      logic r;
      v   = ($urandom_range(0, 99) < 60);
      rdy = ($urandom_range(0, 99) < 55);
      f   = ($urandom_range(0, 199) == 0);
      r   = ($urandom_range(0, 499) == 0);
      cycle(r, f, v, pc_ctr, $urandom, rdy);
      pc_ctr = pc_ctr + 32'h4;
    end

    // Drain and settle.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 32'h0, 32'h0, 1);
    chk("final_occ", 64'(occupancy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC path.
REQ-002 Parameter INST_W, default 32, width of instruction path.
REQ-003 Parameter RESET_PC, default 0 (ADDR_W bits), id_pc value after reset/flush.
REQ-004 Parameter NOP_INST, default 0 (INST_W bits), id_inst value after reset/flush.
REQ-005 Port clk  in  1  single clock; all state updates on rising edge.
REQ-006 Port rst  in  1  reset; synchronous, active-high.
REQ-007 Port flush  in  1  discards all held entries.
REQ-008 Port if_valid  in  1  IF offers a beat.
REQ-009 Port if_ready  out  1  stage can accept; driven directly from a register.
REQ-010 Port if_pc  in  ADDR_W  fetched PC.
REQ-011 Port if_inst  in  INST_W  fetched instruction.
REQ-012 Port id_valid  out  1  id_pc/id_inst hold a valid beat.
REQ-013 Port id_ready  in  1  ID consumes the beat.
REQ-014 Port id_pc  out  ADDR_W  registered PC to ID.
REQ-015 Port id_inst  out  INST_W  registered instruction to ID.
REQ-016 Port occupancy  out  2  entries held, 0..2.

Function
REQ-017 Accept = if_valid & if_ready; consume = id_valid & id_ready; both evaluated on the same edge.
REQ-018 The stage holds two entries: main (drives id_*) and skid; states EMPTY, ONE, TWO; occupancy = 0/1/2.
REQ-019 EMPTY: accept -> ONE, main loaded; else stay.
REQ-020 ONE: accept & consume -> ONE, main loaded with new beat; accept only -> TWO, skid loaded; consume only -> EMPTY; neither -> stay.
REQ-021 TWO: consume -> ONE, main loaded from skid, skid cleared; else stay; no accept possible.
REQ-022 if_ready shall be registered as 1 when next state is EMPTY or ONE, 0 when next state is TWO.
REQ-023 Latency: beat accepted at edge N is presented on id_* with id_valid=1 after edge N; sustained throughput one beat per cycle with id_ready held high.
REQ-024 While id_valid=1 and id_ready=0, id_pc/id_inst shall not change.
REQ-025 Beats leave in acceptance order; none dropped or duplicated except on flush.
REQ-026 When id_valid=0, id_pc/id_inst hold their last values.
REQ-027 Flush has priority over accept/consume: next state EMPTY, id_valid=0, id_pc=RESET_PC, id_inst=NOP_INST, if_ready=1; a beat offered in the flush cycle is discarded and counts as taken by IF.

Reset
REQ-028 rst has priority over flush; when sampled high: state EMPTY, id_valid=0, id_pc=RESET_PC, id_inst=NOP_INST, skid contents cleared, occupancy=0, if_ready=1.
REQ-029 Reset mid-operation discards all entries; no beat accepted in the reset cycle.

Structure
REQ-030 The occupancy state encoding and default RESET_PC/NOP_INST constants shall live in the shared CPU package.
REQ-031 Single module; no sub-module. Main and skid entries are plain registers.

Verification
REQ-032 Stream: reset, then if_valid=1 with pc 0x0,0x4,0x8 on consecutive cycles, id_ready=1 -> id_pc 0x0,0x4,0x8 on the three following cycles, id_valid=1, occupancy=1.
REQ-033 Backpressure: id_ready=0 while pc 0x10,0x14 offered -> occupancy 2, if_ready=0, id_pc stays 0x10; raise id_ready -> 0x10 then 0x14 delivered, if_ready returns 1.
REQ-034 Flush in TWO with if_valid=1 pc 0x20 -> next cycle id_valid=0, id_inst=NOP_INST, id_pc=RESET_PC, occupancy=0, 0x20 never appears.
REQ-035 Reset while occupancy=2 -> all outputs at reset values after one edge; rst and flush both high behaves as reset.
REQ-036 Random if_valid/id_ready (10k cycles) vs. scoreboard FIFO -> in-order, lossless, id_* stable while stalled.
